// File: rtl/nf10_axis_rec_arbiter_pkg.sv
// Shared definitions for the recorder-sink arbiter.
//   state_e   : FSM encoding (IDLE waits for a request, BUSY owns the sink
//               for one whole packet)
//   GRANT_W   : width of the grant index and the round-robin pointer
//   MAX_PORTS : largest port count the grant index can address
//   rr_next   : pointer advance, (cur + 1) mod n
package nf10_axis_rec_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int GRANT_W   = 3;
  localparam int MAX_PORTS = 8;

  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] cur,
                                                 input int                 n);
    if (int'(cur) >= n - 1) return '0;
    return cur + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/nf10_rr_select.sv
// Combinational round-robin pick. Scans req_i starting at ptr_i and wrapping
// modulo C_NUM_PORTS; returns the first requesting port.
//   req_i [C_NUM_PORTS] : per-port request (tvalid)
//   ptr_i [GRANT_W]     : highest-priority port for this pick
//   idx_o [GRANT_W]     : selected port (0 when nothing requests)
//   any_o               : 1 when at least one port requests
module nf10_rr_select
  import nf10_axis_rec_arbiter_pkg::*;
#(
  parameter int C_NUM_PORTS = 4
) (
  input  logic [C_NUM_PORTS-1:0] req_i,
  input  logic [GRANT_W-1:0]     ptr_i,
  output logic [GRANT_W-1:0]     idx_o,
  output logic                   any_o
);

  // Requests widened to the full index range so a GRANT_W-bit candidate can
  // index them directly for any legal port count.
  logic [MAX_PORTS-1:0] req_ext;
  logic [GRANT_W:0]     sum;
  logic [GRANT_W-1:0]   cand;

  always_comb begin
    req_ext = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) req_ext[i] = req_i[i];
  end

  // Walk offsets from farthest to nearest so the nearest requester (smallest
  // offset from ptr_i) is the one left standing.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = C_NUM_PORTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (GRANT_W+1)'(k);
      if (sum >= (GRANT_W+1)'(C_NUM_PORTS)) sum = sum - (GRANT_W+1)'(C_NUM_PORTS);
      cand = sum[GRANT_W-1:0];
      if (req_ext[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nf10_axis_rec_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI4-Stream recorder sink
// from C_NUM_PORTS source streams. A port owns the sink from grant until its
// tlast beat is accepted, so packets never interleave. One idle cycle
// separates packets while the next owner is chosen.
// Ports:
//   aclk, aresetn          clock; asynchronous active-low reset
//   en                     1 = new grants allowed; 0 = finish packet, then hold
//   s_axis_*               packed slave streams, port i at [i*W +: W]
//   s_axis_tready          per-port ready, only the granted port sees m_axis_tready
//   m_axis_*               stream to the recorder (combinational mux of grant)
//   grant                  index of the port owning (or last owning) the sink
//   busy                   1 while a packet is in progress
//   pkt_count              packed per-port completed-packet counters (wrapping)
module nf10_axis_rec_arbiter
  import nf10_axis_rec_arbiter_pkg::*;
#(
  parameter int C_NUM_PORTS          = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH          = 8
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic                                          en,
  input  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  output logic [GRANT_W-1:0]                            grant,
  output logic                                          busy,
  output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]            pkt_count
);

  localparam int N  = C_NUM_PORTS;
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int CW = C_CNT_WIDTH;

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q [N];
  logic [CW-1:0]      cnt_d [N];

  logic [GRANT_W-1:0] sel_idx;
  logic               sel_any;
  logic               sel_vld;
  logic               sel_last;
  logic               busy_w;

  nf10_rr_select #(
    .C_NUM_PORTS(N)
  ) u_rr_select (
    .req_i (s_axis_tvalid),
    .ptr_i (ptr_q),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  assign busy_w = (state_q == ST_BUSY);
  assign busy   = busy_w;
  assign grant  = grant_q;

  // Payload mux follows grant_q in every state; in IDLE the payload is a
  // don't-care and tvalid is forced low.
  always_comb begin
    m_axis_tdata = s_axis_tdata[DW-1:0];
    m_axis_tstrb = s_axis_tstrb[SW-1:0];
    m_axis_tuser = s_axis_tuser[UW-1:0];
    sel_vld      = s_axis_tvalid[0];
    sel_last     = s_axis_tlast[0];
    for (int i = 1; i < N; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        m_axis_tdata = s_axis_tdata[i*DW +: DW];
        m_axis_tstrb = s_axis_tstrb[i*SW +: SW];
        m_axis_tuser = s_axis_tuser[i*UW +: UW];
        sel_vld      = s_axis_tvalid[i];
        sel_last     = s_axis_tlast[i];
      end
    end
  end

  assign m_axis_tvalid = busy_w & sel_vld;
  assign m_axis_tlast  = sel_last;

  // Ready reaches only the owning port; requesters waiting for their turn
  // see 0, so none of their beats are consumed early.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < N; i++) begin
      s_axis_tready[i] = busy_w & (grant_q == GRANT_W'(i)) & m_axis_tready;
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < N; i++) pkt_count[i*CW +: CW] = cnt_q[i];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && sel_any) begin
          state_d = ST_BUSY;
          grant_d = sel_idx;
        end
      end
      ST_BUSY: begin
        // Packet ends on the accepted tlast beat; the finishing port drops to
        // lowest priority for the next pick.
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = ST_IDLE;
          ptr_d   = rr_next(grant_q, N);
          for (int i = 0; i < N; i++) begin
            if (grant_q == GRANT_W'(i)) cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_nf10_axis_rec_arbiter.sv
module tb_nf10_axis_rec_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int CW = 8;

  logic                aclk;
  logic                aresetn;
  logic                en;
  logic [N*DW-1:0]     s_tdata;
  logic [N*SW-1:0]     s_tstrb;
  logic [N*UW-1:0]     s_tuser;
  logic [N-1:0]        s_tvalid;
  logic [N-1:0]        s_tlast;
  logic [N-1:0]        s_tready;
  logic [DW-1:0]       m_tdata;
  logic [SW-1:0]       m_tstrb;
  logic [UW-1:0]       m_tuser;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tready;
  logic [2:0]          grant;
  logic                busy;
  logic [N*CW-1:0]     pkt_count;

  logic [DW-1:0] d_dat  [N];
  logic [SW-1:0] d_strb [N];
  logic [UW-1:0] d_usr  [N];

  int total = 0;
  int bad   = 0;

  nf10_axis_rec_arbiter dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .en            (en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant         (grant),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always_comb begin
    for (int p = 0; p < N; p++) begin
      s_tdata[p*DW +: DW] = d_dat[p];
      s_tstrb[p*SW +: SW] = d_strb[p];
      s_tuser[p*UW +: UW] = d_usr[p];
    end
  end

  function automatic logic [DW-1:0] dat(input int p, input int b);
    logic [31:0] w;
    w = {4'hA, p[3:0], b[7:0], 16'h5EED};
    return {8{w}};
  endfunction

  function automatic logic [SW-1:0] strb(input int p, input int b);
    return {p[7:0], b[7:0], ~p[7:0], ~b[7:0]};
  endfunction

  function automatic logic [UW-1:0] usr(input int p, input int b);
    logic [31:0] w;
    w = {8'hC0, p[7:0], b[15:0]};
    return {4{w}};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic set_beat(input int p, input int b, input logic last);
    d_dat[p]    = dat(p, b);
    d_strb[p]   = strb(p, b);
    d_usr[p]    = usr(p, b);
    s_tlast[p]  = last;
    s_tvalid[p] = 1'b1;
  endtask

  task automatic apply_reset();
    s_tvalid = '0;
    s_tlast  = '0;
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    total++; if (grant !== 3'd0) begin bad++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL reset_s_tready: got %b expected 0000", s_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid: got %0b expected 0", m_tvalid); end
    total++; if (pkt_count !== 32'd0) begin bad++; $display("FAIL reset_pkt_count: got %h expected 0", pkt_count); end
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_single_packet();
    en = 1'b1;
    m_tready = 1'b1;
    set_beat(1, 0, 1'b0);
    mid();
    total++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin bad++; $display("FAIL sp_bubble: got tvalid=%0b ready=%b expected 0 0000", m_tvalid, s_tready); end
    tick();
    mid();
    total++; if (grant !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL sp_grant: got grant=%0d busy=%0b expected 1 1", grant, busy); end
    total++; if (m_tvalid !== 1'b1 || m_tdata !== dat(1, 0)) begin bad++; $display("FAIL sp_beat0: got v=%0b %h expected 1 %h", m_tvalid, m_tdata, dat(1, 0)); end
    total++; if (s_tready !== 4'b0010) begin bad++; $display("FAIL sp_ready: got %b expected 0010", s_tready); end
    tick();
    set_beat(1, 1, 1'b0);
    mid();
    total++; if (m_tdata !== dat(1, 1) || m_tstrb !== strb(1, 1)) begin bad++; $display("FAIL sp_beat1: got %h/%h expected %h/%h", m_tdata, m_tstrb, dat(1, 1), strb(1, 1)); end
    tick();
    set_beat(1, 2, 1'b1);
    mid();
    total++; if (m_tdata !== dat(1, 2) || m_tuser !== usr(1, 2) || m_tlast !== 1'b1) begin bad++; $display("FAIL sp_beat2: got %h/%h last=%0b expected %h/%h 1", m_tdata, m_tuser, m_tlast, dat(1, 2), usr(1, 2)); end
    tick();
    s_tvalid[1] = 1'b0;
    s_tlast[1]  = 1'b0;
    mid();
    total++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL sp_end_busy: got busy=%0b v=%0b expected 0 0", busy, m_tvalid); end
    total++; if (pkt_count[15:8] !== 8'd1) begin bad++; $display("FAIL sp_count1: got %0d expected 1", pkt_count[15:8]); end
    total++; if (grant !== 3'd1) begin bad++; $display("FAIL sp_grant_hold: got %0d expected 1", grant); end
  endtask

  task automatic test_all_ports();
    int g;
    apply_reset();
    en = 1'b1;
    m_tready = 1'b1;
    for (int p = 0; p < N; p++) set_beat(p, 0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      g = n % N;
      mid();
      total++; if (busy !== 1'b0 || s_tready !== 4'b0000) begin bad++; $display("FAIL ap_idle%0d: got busy=%0b ready=%b expected 0 0000", n, busy, s_tready); end
      tick();
      mid();
      total++; if (grant !== 3'(g)) begin bad++; $display("FAIL ap_grant%0d: got %0d expected %0d", n, grant, g); end
      total++; if (m_tdata !== dat(g, n / N) || s_tready !== 4'(1 << g)) begin bad++; $display("FAIL ap_data%0d: got %h ready=%b expected %h ready=%b", n, m_tdata, s_tready, dat(g, n / N), 4'(1 << g)); end
      tick();
      if (n == 7) s_tvalid = '0;
      else set_beat(g, n / N + 1, 1'b1);
    end
    mid();
    total++; if (pkt_count !== {4{8'd2}}) begin bad++; $display("FAIL ap_counts: got %h expected 02020202", pkt_count); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL ap_quiet: got %0b expected 0", m_tvalid); end
  endtask

  task automatic test_stall();
    set_beat(2, 0, 1'b0);
    tick();
    set_beat(0, 0, 1'b1);
    mid();
    total++; if (grant !== 3'd2 || m_tdata !== dat(2, 0) || s_tready !== 4'b0100) begin bad++; $display("FAIL st_start: got g=%0d %h r=%b expected 2 %h 0100", grant, m_tdata, s_tready, dat(2, 0)); end
    tick();
    set_beat(2, 1, 1'b0);
    m_tready = 1'b0;
    mid();
    total++; if (m_tvalid !== 1'b1 || s_tready !== 4'b0000 || m_tdata !== dat(2, 1)) begin bad++; $display("FAIL st_stall: got v=%0b r=%b %h expected 1 0000 %h", m_tvalid, s_tready, m_tdata, dat(2, 1)); end
    tick();
    m_tready = 1'b1;
    s_tvalid[2] = 1'b0;
    mid();
    total++; if (m_tvalid !== 1'b0 || busy !== 1'b1 || grant !== 3'd2 || s_tready !== 4'b0100) begin bad++; $display("FAIL st_gap: got v=%0b busy=%0b g=%0d r=%b expected 0 1 2 0100", m_tvalid, busy, grant, s_tready); end
    tick();
    s_tvalid[2] = 1'b1;
    mid();
    total++; if (m_tdata !== dat(2, 1) || s_tready[0] !== 1'b0) begin bad++; $display("FAIL st_resume: got %h r0=%0b expected %h 0", m_tdata, s_tready[0], dat(2, 1)); end
    tick();
    set_beat(2, 2, 1'b1);
    mid();
    total++; if (m_tdata !== dat(2, 2) || m_tlast !== 1'b1 || s_tready !== 4'b0100) begin bad++; $display("FAIL st_last: got %h last=%0b r=%b expected %h 1 0100", m_tdata, m_tlast, s_tready, dat(2, 2)); end
    tick();
    s_tvalid[2] = 1'b0;
    s_tlast[2]  = 1'b0;
    mid();
    total++; if (busy !== 1'b0 || pkt_count[23:16] !== 8'd3 || s_tready !== 4'b0000) begin bad++; $display("FAIL st_done: got busy=%0b c2=%0d r=%b expected 0 3 0000", busy, pkt_count[23:16], s_tready); end
    tick();
    mid();
    total++; if (grant !== 3'd0 || m_tdata !== dat(0, 0) || s_tready !== 4'b0001) begin bad++; $display("FAIL st_next: got g=%0d %h r=%b expected 0 %h 0001", grant, m_tdata, s_tready, dat(0, 0)); end
    tick();
    s_tvalid[0] = 1'b0;
    mid();
    total++; if (busy !== 1'b0 || pkt_count[7:0] !== 8'd3) begin bad++; $display("FAIL st_count0: got busy=%0b c0=%0d expected 0 3", busy, pkt_count[7:0]); end
  endtask

  task automatic test_en_pause();
    set_beat(3, 0, 1'b0);
    tick();
    mid();
    total++; if (grant !== 3'd3 || busy !== 1'b1) begin bad++; $display("FAIL en_grant3: got g=%0d busy=%0b expected 3 1", grant, busy); end
    tick();
    en = 1'b0;
    set_beat(3, 1, 1'b1);
    set_beat(1, 0, 1'b1);
    mid();
    total++; if (busy !== 1'b1 || m_tdata !== dat(3, 1)) begin bad++; $display("FAIL en_finish: got busy=%0b %h expected 1 %h", busy, m_tdata, dat(3, 1)); end
    tick();
    s_tvalid[3] = 1'b0;
    mid();
    total++; if (busy !== 1'b0 || pkt_count[31:24] !== 8'd3) begin bad++; $display("FAIL en_done: got busy=%0b c3=%0d expected 0 3", busy, pkt_count[31:24]); end
    for (int k = 0; k < 3; k++) begin
      tick();
      mid();
      total++; if (busy !== 1'b0 || grant !== 3'd3 || s_tready !== 4'b0000) begin bad++; $display("FAIL en_hold%0d: got busy=%0b g=%0d r=%b expected 0 3 0000", k, busy, grant, s_tready); end
    end
    en = 1'b1;
    tick();
    mid();
    total++; if (grant !== 3'd1 || busy !== 1'b1 || m_tdata !== dat(1, 0)) begin bad++; $display("FAIL en_release: got g=%0d busy=%0b %h expected 1 1 %h", grant, busy, m_tdata, dat(1, 0)); end
    tick();
    s_tvalid[1] = 1'b0;
    mid();
    total++; if (busy !== 1'b0 || pkt_count[15:8] !== 8'd3) begin bad++; $display("FAIL en_count1: got busy=%0b c1=%0d expected 0 3", busy, pkt_count[15:8]); end
  endtask

  task automatic test_wrap();
    apply_reset();
    en = 1'b1;
    m_tready = 1'b1;
    set_beat(0, 0, 1'b1);
    for (int n = 0; n < 255; n++) begin
      tick();
      if (n < 2) begin
        mid();
        total++; if (grant !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL wr_busy%0d: got g=%0d busy=%0b expected 0 1", n, grant, busy); end
      end
      tick();
      if (n < 2) begin
        mid();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_bubble%0d: got busy=%0b expected 0", n, busy); end
      end
    end
    mid();
    total++; if (pkt_count[7:0] !== 8'd255) begin bad++; $display("FAIL wr_255: got %0d expected 255", pkt_count[7:0]); end
    tick();
    tick();
    s_tvalid[0] = 1'b0;
    mid();
    total++; if (pkt_count[7:0] !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL wr_wrap: got c0=%0d busy=%0b expected 0 0", pkt_count[7:0], busy); end
  endtask

  task automatic test_async_reset();
    set_beat(1, 0, 1'b1);
    tick();
    tick();
    s_tvalid[1] = 1'b0;
    set_beat(2, 0, 1'b0);
    mid();
    total++; if (pkt_count[15:8] !== 8'd1) begin bad++; $display("FAIL ar_pre_count: got %0d expected 1", pkt_count[15:8]); end
    tick();
    mid();
    total++; if (grant !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL ar_pre_grant: got g=%0d busy=%0b expected 2 1", grant, busy); end
    tick();
    set_beat(2, 1, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin bad++; $display("FAIL ar_outputs: got v=%0b r=%b expected 0 0000", m_tvalid, s_tready); end
    total++; if (grant !== 3'd0 || busy !== 1'b0 || pkt_count !== 32'd0) begin bad++; $display("FAIL ar_state: got g=%0d busy=%0b cnt=%h expected 0 0 0", grant, busy, pkt_count); end
    s_tvalid = '0;
    s_tlast  = '0;
    tick();
    aresetn = 1'b1;
    tick();
    set_beat(3, 0, 1'b0);
    mid();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_idle: got %0b expected 0", busy); end
    tick();
    mid();
    total++; if (grant !== 3'd3 || m_tdata !== dat(3, 0)) begin bad++; $display("FAIL ar_beat0: got g=%0d %h expected 3 %h", grant, m_tdata, dat(3, 0)); end
    tick();
    set_beat(3, 1, 1'b1);
    mid();
    total++; if (m_tdata !== dat(3, 1) || m_tlast !== 1'b1) begin bad++; $display("FAIL ar_beat1: got %h last=%0b expected %h 1", m_tdata, m_tlast, dat(3, 1)); end
    tick();
    s_tvalid[3] = 1'b0;
    mid();
    total++; if (busy !== 1'b0 || pkt_count !== {8'd1, 24'd0}) begin bad++; $display("FAIL ar_after: got busy=%0b cnt=%h expected 0 01000000", busy, pkt_count); end
  endtask

  initial begin
    aresetn  = 1'b0;
    en       = 1'b0;
    m_tready = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int p = 0; p < N; p++) begin
      d_dat[p]  = '0;
      d_strb[p] = '0;
      d_usr[p]  = '0;
    end
    test_reset();
    test_single_packet();
    test_all_ports();
    test_stall();
    test_en_pause();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
